// File: rtl/ram4002_slave.sv
// ===========================================================================
// Module  : ram4002_slave
// Brief   : 4002-style RAM chip bus slave; it decodes SRC and E-page I/O
//           instructions and holds 80 nibbles of storage plus an output port.
// Rev     : 1.0  initial release
// ===========================================================================
`default_nettype none

module ram4002_slave #(
    parameter logic [1:0] Chip_id = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       cm_ram,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_oe,
    output logic [3:0] port_out
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    localparam logic [3:0] c_opr_io = 4'b1110;
    localparam logic [3:0] c_wrm    = 4'b0000;
    localparam logic [3:0] c_wmp    = 4'b0001;
    localparam logic [3:0] c_sbm    = 4'b1000;
    localparam logic [3:0] c_rdm    = 4'b1001;
    localparam logic [3:0] c_adm    = 4'b1011;

    phase_t     r_phase;
    logic       r_aligned;
    logic       r_selected;
    logic       r_src_pending;
    logic       r_io_pending;
    logic [1:0] r_reg_idx;
    logic [3:0] r_char_idx;
    logic [3:0] r_opr;
    logic [3:0] r_opa;

    // Storage is deliberately left without reset.
    logic [3:0] r_main   [0:63];
    logic [3:0] r_status [0:15];

    logic       w_early_sync;
    logic       w_act;
    logic       w_is_wrm;
    logic       w_is_wmp;
    logic       w_is_wrn;
    logic       w_is_rdm;
    logic       w_is_rdn;
    logic       w_exec_x2;
    logic       w_drive_x1;
    logic [5:0] w_main_addr;
    logic [3:0] w_stat_addr;
    logic [3:0] w_rd_data;

    // A sync outside X3 aborts whatever the current instruction was doing.
    assign w_early_sync = sync && (r_phase != PH_X3);
    assign w_act        = r_aligned && !w_early_sync;

    assign w_is_wrm = (r_opa == c_wrm);
    assign w_is_wmp = (r_opa == c_wmp);
    assign w_is_wrn = (r_opa[3:2] == 2'b01);
    assign w_is_rdm = (r_opa == c_sbm) || (r_opa == c_rdm) || (r_opa == c_adm);
    assign w_is_rdn = (r_opa[3:2] == 2'b11);

    assign w_main_addr = {r_reg_idx, r_char_idx};
    assign w_stat_addr = {r_reg_idx, r_opa[1:0]};
    assign w_rd_data   = w_is_rdn ? r_status[w_stat_addr] : r_main[w_main_addr];

    assign w_exec_x2  = w_act && r_io_pending && (r_phase == PH_X2);
    assign w_drive_x1 = w_act && r_io_pending && (r_phase == PH_X1) && (w_is_rdm || w_is_rdn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase       <= PH_X3;
            r_aligned     <= 1'b0;
            r_selected    <= 1'b0;
            r_src_pending <= 1'b0;
            r_io_pending  <= 1'b0;
            r_reg_idx     <= 2'd0;
            r_char_idx    <= 4'd0;
            r_opr         <= 4'd0;
            r_opa         <= 4'd0;
            data_out      <= 4'h0;
            data_oe       <= 1'b0;
            port_out      <= 4'h0;
        end else begin
            if (sync) begin
                r_phase   <= PH_A1;
                r_aligned <= 1'b1;
            end else if (r_phase != PH_X3) begin
                r_phase <= phase_t'(r_phase + 3'd1);
            end

            // Read data is launched on the X1->X2 edge so it is on the bus for X2 only.
            data_oe  <= w_drive_x1;
            data_out <= w_drive_x1 ? w_rd_data : 4'h0;

            if (w_exec_x2 && w_is_wmp) begin
                port_out <= data_in;
            end

            if (w_early_sync) begin
                r_src_pending <= 1'b0;
                r_io_pending  <= 1'b0;
            end else if (r_aligned) begin
                case (r_phase)
                    PH_M1: begin
                        r_opr <= data_in;
                    end
                    PH_M2: begin
                        if (cm_ram && (r_opr == c_opr_io) && r_selected) begin
                            r_opa        <= data_in;
                            r_io_pending <= 1'b1;
                        end else begin
                            r_io_pending <= 1'b0;
                        end
                    end
                    PH_X2: begin
                        if (cm_ram) begin
                            r_reg_idx     <= data_in[1:0];
                            r_selected    <= (data_in[3:2] == Chip_id);
                            r_src_pending <= 1'b1;
                        end else begin
                            r_src_pending <= 1'b0;
                        end
                    end
                    PH_X3: begin
                        if (r_src_pending && r_selected) begin
                            r_char_idx <= data_in;
                        end
                        r_src_pending <= 1'b0;
                        r_io_pending  <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_exec_x2 && !rst) begin
            if (w_is_wrm) begin
                r_main[w_main_addr] <= data_in;
            end
            if (w_is_wrn) begin
                r_status[w_stat_addr] <= data_in;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram4002_slave.sv
// ===========================================================================
// Module  : tb_ram4002_slave
// Brief   : Self-checking bench for ram4002_slave driven at instruction level.
// Rev     : 1.0  initial release
// ===========================================================================
`default_nettype none

module tb_ram4002_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cm_ram;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_oe;
    logic [3:0] port_out;

    always #5 clk = ~clk;

    ram4002_slave #(.Chip_id(2'd1)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .cm_ram   (cm_ram),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .port_out (port_out)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] cap_out;
    logic       cap_oe;
    logic [3:0] cap_port;

    // Instruction-level reference state.
    logic [3:0] m_main [4][16];
    logic [3:0] m_st   [4][4];
    logic [3:0] m_port;
    bit         m_sel;
    logic [1:0] m_reg;
    logic [3:0] m_char;

    typedef struct {
        logic [3:0] opr;
        logic [3:0] opa;
        logic       cm_m2;
        logic [3:0] x2d;
        logic [3:0] x3d;
        logic       cm_x2;
        logic       exp_oe;
        logic [3:0] exp_out;
        logic [3:0] exp_port;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] d, input logic c, input logic s);
        @(negedge clk);
        cap_oe   = data_oe;
        cap_out  = data_out;
        cap_port = port_out;
        data_in  = d;
        cm_ram   = c;
        sync     = s;
    endtask

    function automatic void model_instr(input logic [3:0] opr, input logic [3:0] opa,
                                        input logic cm_m2, input logic [3:0] x2d,
                                        input logic [3:0] x3d, input logic cm_x2,
                                        output logic eoe, output logic [3:0] eout);
        int o;
        eoe  = 1'b0;
        eout = 4'h0;
        o    = int'(opa);
        if (opr == 4'hE && cm_m2 && m_sel) begin
            if (o == 0)                       m_main[m_reg][m_char] = x2d;
            else if (o == 1)                  m_port = x2d;
            else if (o >= 4 && o <= 7)        m_st[m_reg][o % 4] = x2d;
            else if (o == 8 || o == 9 || o == 11) begin
                eoe  = 1'b1;
                eout = m_main[m_reg][m_char];
            end else if (o >= 12) begin
                eoe  = 1'b1;
                eout = m_st[m_reg][o % 4];
            end
        end
        if (cm_x2) begin
            m_sel = (x2d[3:2] == 2'd1);
            m_reg = x2d[1:0];
            if (m_sel) m_char = x3d;
        end
    endfunction

    // Runs one 8-subcycle instruction (sync raised at subcycle sync_at) and checks it.
    task automatic do_instr(input string name, input logic [3:0] opr, input logic [3:0] opa,
                            input logic cm_m2, input logic [3:0] x2d, input logic [3:0] x3d,
                            input logic cm_x2, input int sync_at, input logic eoe,
                            input logic [3:0] eout, input logic [3:0] eport);
        logic       stray = 1'b0;
        logic       x2_oe = 1'b0;
        logic [3:0] x2_out = 4'h0;
        logic [3:0] d;
        logic       c;
        for (int p = 0; p <= sync_at; p++) begin
            d = 4'($urandom_range(0, 15));
            c = 1'b0;
            if (p == 3) d = opr;
            if (p == 4) begin d = opa; c = cm_m2; end
            if (p == 6) begin d = x2d; c = cm_x2; end
            if (p == 7) d = x3d;
            cyc(d, c, (p == sync_at));
            if (p == 6) begin
                x2_oe  = cap_oe;
                x2_out = cap_out;
            end else if (cap_oe !== 1'b0 || cap_out !== 4'h0) begin
                stray = 1'b1;
            end
        end
        chk({name, " stray_drive"}, {7'd0, stray}, 8'd0);
        chk({name, " x2_oe"}, {7'd0, x2_oe}, {7'd0, eoe});
        chk({name, " x2_out"}, {4'd0, x2_out}, {4'd0, eout});
        chk({name, " port"}, {4'd0, cap_port}, {4'd0, eport});
    endtask

    task automatic model_and_run(input string name, input logic [3:0] opr, input logic [3:0] opa,
                                 input logic cm_m2, input logic [3:0] x2d, input logic [3:0] x3d,
                                 input logic cm_x2);
        logic       eoe;
        logic [3:0] eout;
        model_instr(opr, opa, cm_m2, x2d, x3d, cm_x2, eoe, eout);
        do_instr(name, opr, opa, cm_m2, x2d, x3d, cm_x2, 7, eoe, eout, m_port);
    endtask

    function automatic vec_t mk(input logic [3:0] opr, input logic [3:0] opa, input logic cm_m2,
                                input logic [3:0] x2d, input logic [3:0] x3d, input logic cm_x2,
                                input logic eoe, input logic [3:0] eout, input logic [3:0] eport);
        vec_t v;
        v.opr = opr; v.opa = opa; v.cm_m2 = cm_m2; v.x2d = x2d; v.x3d = x3d;
        v.cm_x2 = cm_x2; v.exp_oe = eoe; v.exp_out = eout; v.exp_port = eport;
        return v;
    endfunction

    initial begin
        logic       eoe;
        logic [3:0] eout;
        int         kind;

        vecs.push_back(mk(4'h2, 4'h0, 0, 4'h6, 4'hA, 1, 0, 4'h0, 4'h0)); // SRC chip1 reg2 char A
        vecs.push_back(mk(4'hE, 4'h0, 1, 4'h7, 4'h0, 0, 0, 4'h0, 4'h0)); // WRM 7
        vecs.push_back(mk(4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 1, 4'h7, 4'h0)); // RDM
        vecs.push_back(mk(4'hE, 4'h6, 1, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0)); // WR2 5
        vecs.push_back(mk(4'hE, 4'h5, 1, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0)); // WR1 3
        vecs.push_back(mk(4'hE, 4'hE, 1, 4'h0, 4'h0, 0, 1, 4'h5, 4'h0)); // RD2
        vecs.push_back(mk(4'hE, 4'hD, 1, 4'h0, 4'h0, 0, 1, 4'h3, 4'h0)); // RD1
        vecs.push_back(mk(4'hE, 4'h1, 1, 4'hC, 4'h0, 0, 0, 4'h0, 4'hC)); // WMP C
        vecs.push_back(mk(4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 1, 4'h7, 4'hC)); // RDM
        vecs.push_back(mk(4'hE, 4'hB, 1, 4'h0, 4'h0, 0, 1, 4'h7, 4'hC)); // ADM
        vecs.push_back(mk(4'hE, 4'h8, 1, 4'h0, 4'h0, 0, 1, 4'h7, 4'hC)); // SBM
        vecs.push_back(mk(4'hE, 4'h2, 1, 4'hF, 4'h0, 0, 0, 4'h0, 4'hC)); // WRR ignored
        vecs.push_back(mk(4'hE, 4'hA, 1, 4'h0, 4'h0, 0, 0, 4'h0, 4'hC)); // RDR ignored
        vecs.push_back(mk(4'hE, 4'h3, 1, 4'hF, 4'h0, 0, 0, 4'h0, 4'hC)); // OPA 3 ignored
        vecs.push_back(mk(4'hE, 4'h9, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'hC)); // cm_ram low at M2
        vecs.push_back(mk(4'hD, 4'h9, 1, 4'h0, 4'h0, 0, 0, 4'h0, 4'hC)); // non-E OPR
        vecs.push_back(mk(4'h2, 4'h0, 0, 4'h2, 4'hA, 1, 0, 4'h0, 4'hC)); // SRC chip0: deselect
        vecs.push_back(mk(4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 0, 4'h0, 4'hC)); // RDM while deselected
        vecs.push_back(mk(4'hE, 4'h1, 1, 4'h3, 4'h0, 0, 0, 4'h0, 4'hC)); // WMP while deselected
        vecs.push_back(mk(4'h2, 4'h0, 0, 4'h6, 4'hA, 1, 0, 4'h0, 4'hC)); // reselect
        vecs.push_back(mk(4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 1, 4'h7, 4'hC)); // RDM

        rst = 1'b1; sync = 1'b0; cm_ram = 1'b0; data_in = 4'h0;
        m_port = 4'h0; m_sel = 0; m_reg = 2'd0; m_char = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset data_oe", {7'd0, data_oe}, 8'd0);
        chk("reset data_out", {4'd0, data_out}, 8'd0);
        chk("reset port_out", {4'd0, port_out}, 8'd0);
        rst = 1'b0;

        // No alignment yet: a full I/O attempt must not drive the bus.
        do_instr("unaligned", 4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 7, 0, 4'h0, 4'h0);

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                model_and_run("init_src", 4'h2, 4'h0, 0, {2'b01, 2'(r)}, 4'(c), 1);
                model_and_run("init_wrm", 4'hE, 4'h0, 1, 4'($urandom_range(0, 15)), 4'h0, 0);
            end
            for (int s = 0; s < 4; s++)
                model_and_run("init_wrn", 4'hE, 4'(4 + s), 1, 4'($urandom_range(0, 15)), 4'h0, 0);
        end

        foreach (vecs[i]) begin
            model_instr(vecs[i].opr, vecs[i].opa, vecs[i].cm_m2, vecs[i].x2d, vecs[i].x3d,
                        vecs[i].cm_x2, eoe, eout);
            do_instr($sformatf("vec%0d", i), vecs[i].opr, vecs[i].opa, vecs[i].cm_m2,
                     vecs[i].x2d, vecs[i].x3d, vecs[i].cm_x2, 7,
                     vecs[i].exp_oe, vecs[i].exp_out, vecs[i].exp_port);
        end

        // WRM cut short by sync at X1: the write must not happen.
        do_instr("early_sync_wrm", 4'hE, 4'h0, 1, 4'h2, 4'h0, 0, 5, 0, 4'h0, 4'hC);
        do_instr("after_early_sync", 4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 7, 1, 4'h7, 4'hC);

        // Reset raised at X1 of a WRM.
        cyc(4'h0, 0, 0); cyc(4'h0, 0, 0); cyc(4'h0, 0, 0);
        cyc(4'hE, 0, 0); cyc(4'h0, 1, 0); cyc(4'h0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid port_out", {4'd0, port_out}, 8'd0);
        chk("rst_mid data_oe", {7'd0, data_oe}, 8'd0);
        cyc(4'h1, 0, 0); cyc(4'h1, 0, 0);
        rst = 1'b0;
        m_port = 4'h0; m_sel = 0; m_reg = 2'd0; m_char = 4'h0;
        cyc(4'h1, 0, 0); cyc(4'h1, 0, 0);
        do_instr("post_rst_unaligned", 4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 7, 0, 4'h0, 4'h0);
        model_and_run("post_rst_src", 4'h2, 4'h0, 0, 4'h6, 4'hA, 1);
        do_instr("post_rst_rdm", 4'hE, 4'h9, 1, 4'h0, 4'h0, 0, 7, 1, 4'h7, 4'h0);

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                model_and_run("rand_src", 4'h2, 4'h0, 0,
                              {($urandom_range(0, 3) == 0) ? 2'd2 : 2'd1, 2'($urandom_range(0, 3))},
                              4'($urandom_range(0, 15)), 1);
            end else begin
                model_and_run("rand_io", (kind == 9) ? 4'($urandom_range(0, 15)) : 4'hE,
                              4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
                              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
